// File: rtl/mips_pkg.sv
// Opcode/funct constants, FSM state encoding and the register match helper
// shared by the hazard controller and its ID-stage decoder.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_LUI    = 6'h0f;
    localparam logic [5:0] OP_SW     = 6'h2b;

    localparam logic [5:0] FN_JR     = 6'h08;
    localparam logic [5:0] FN_JALR   = 6'h09;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_STALL  = 2'd1;
    localparam logic [1:0] ST_FREEZE = 2'd2;

    // $0 is hardwired to zero, so it never creates a dependency.
    function automatic logic reg_match(input logic we, input logic [4:0] rd, input logic [4:0] src);
        return we && (rd != 5'd0) && (rd == src);
    endfunction

endpackage

// File: rtl/hz_decode.sv
// Classifies the ID-stage instruction: which source fields it reads and
// whether it is a branch/jump-register resolved in ID.
module hz_decode
    import mips_pkg::*;
(
    input  logic [31:0] id_ins,
    output logic        uses_rs,
    output logic        uses_rt,
    output logic        is_br,
    output logic        br_rt
);

    logic [5:0] op;
    logic [5:0] funct;
    logic       unused_bits;

    assign op          = id_ins[31:26];
    assign funct       = id_ins[5:0];
    assign unused_bits = ^id_ins[25:6];

    assign uses_rs = !((op == OP_J) || (op == OP_JAL) || (op == OP_LUI));
    assign uses_rt = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    assign br_rt   = (op == OP_BEQ) || (op == OP_BNE);
    assign is_br   = (op == OP_REGIMM) || br_rt || (op == OP_BLEZ) || (op == OP_BGTZ) ||
                     ((op == OP_RTYPE) && ((funct == FN_JR) || (funct == FN_JALR)));

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for a 5-stage MIPS with branches resolved in
// ID: stall/bubble/flush/freeze control, ID forwarding and perf counters.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      id_ins,
    input  logic [1:0]       id_pc_src,
    input  logic             id_ex_mem_read,
    input  logic             id_ex_reg_write,
    input  logic [4:0]       id_ex_rd,
    input  logic             ex_mem_mem_read,
    input  logic             ex_mem_reg_write,
    input  logic [4:0]       ex_mem_rd,
    input  logic             mem_wait,
    input  logic             clr_cnt,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             pipe_en,
    output logic             control_sel,
    output logic             if_flush,
    output logic             forward_c,
    output logic             forward_d,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs, uses_rt, is_br, br_rt;
    logic       ex_rs, ex_rt, mem_rs, mem_rt;
    logic       h1, h2, h3, need_stall;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    assign rs = id_ins[25:21];
    assign rt = id_ins[20:16];

    hz_decode u_decode (
        .id_ins  (id_ins),
        .uses_rs (uses_rs),
        .uses_rt (uses_rt),
        .is_br   (is_br),
        .br_rt   (br_rt)
    );

    assign ex_rs  = reg_match(id_ex_reg_write, id_ex_rd, rs);
    assign ex_rt  = reg_match(id_ex_reg_write, id_ex_rd, rt);
    assign mem_rs = reg_match(ex_mem_reg_write, ex_mem_rd, rs);
    assign mem_rt = reg_match(ex_mem_reg_write, ex_mem_rd, rt);

    assign h1 = id_ex_mem_read && ((uses_rs && ex_rs) || (uses_rt && ex_rt));
    assign h2 = is_br && (ex_rs || (br_rt && ex_rt));
    assign h3 = is_br && ex_mem_mem_read && (mem_rs || (br_rt && mem_rt));
    assign need_stall = h1 || h2 || h3;

    // Loads in MEM are covered by H3, so only ALU results are forwarded.
    assign forward_c = is_br && !ex_mem_mem_read && mem_rs;
    assign forward_d = is_br && br_rt && !ex_mem_mem_read && mem_rt;

    always_comb begin
        state_d     = ST_RUN;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        pipe_en     = 1'b1;
        control_sel = 1'b1;
        if_flush    = 1'b0;
        if (reset && mem_wait) begin
            state_d     = ST_FREEZE;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_en     = 1'b0;
        end else if (reset && need_stall) begin
            state_d     = ST_STALL;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            control_sel = 1'b0;
        end else begin
            if_flush = (id_pc_src != 2'b00);
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (clr_cnt) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if ((state_d == ST_STALL) && (stall_cnt_q != '1))
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (if_flush && (flush_cnt_q != '1))
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign state       = state_q;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hand-computed stall/flush/freeze/forwarding
// expectations, counters narrowed to 4 bits so saturation is reachable.
module tb_hazard_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   id_ins;
    logic [1:0]    id_pc_src;
    logic          id_ex_mem_read, id_ex_reg_write;
    logic [4:0]    id_ex_rd;
    logic          ex_mem_mem_read, ex_mem_reg_write;
    logic [4:0]    ex_mem_rd;
    logic          mem_wait, clr_cnt;
    logic          pc_write, if_id_write, pipe_en, control_sel, if_flush;
    logic          forward_c, forward_d;
    logic [1:0]    state;
    logic [CW-1:0] stall_count, flush_count;

    int total = 0;
    int bad   = 0;
    int exp_stall;
    int exp_flush;

    hazard_ctrl #(.CNT_W(CW)) dut (
        .clk              (clk),
        .reset            (reset),
        .id_ins           (id_ins),
        .id_pc_src        (id_pc_src),
        .id_ex_mem_read   (id_ex_mem_read),
        .id_ex_reg_write  (id_ex_reg_write),
        .id_ex_rd         (id_ex_rd),
        .ex_mem_mem_read  (ex_mem_mem_read),
        .ex_mem_reg_write (ex_mem_reg_write),
        .ex_mem_rd        (ex_mem_rd),
        .mem_wait         (mem_wait),
        .clr_cnt          (clr_cnt),
        .pc_write         (pc_write),
        .if_id_write      (if_id_write),
        .pipe_en          (pipe_en),
        .control_sel      (control_sel),
        .if_flush         (if_flush),
        .forward_c        (forward_c),
        .forward_d        (forward_d),
        .state            (state),
        .stall_count      (stall_count),
        .flush_count      (flush_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt);
        return {6'(op), 5'(rs), 5'(rt), 16'h0010};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic ctl(input string tag, input logic pcw, input logic ifid, input logic pen,
                       input logic csel, input logic fl);
        chk({tag, ".pc_write"}, 32'(pc_write), 32'(pcw));
        chk({tag, ".if_id_write"}, 32'(if_id_write), 32'(ifid));
        chk({tag, ".pipe_en"}, 32'(pipe_en), 32'(pen));
        chk({tag, ".control_sel"}, 32'(control_sel), 32'(csel));
        chk({tag, ".if_flush"}, 32'(if_flush), 32'(fl));
    endtask

    task automatic regs(input string tag, input int st);
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".stall_count"}, 32'(stall_count), 32'(exp_stall));
        chk({tag, ".flush_count"}, 32'(flush_count), 32'(exp_flush));
    endtask

    task automatic idle();
        id_ins = 32'h0; id_pc_src = 2'b00;
        id_ex_mem_read = 1'b0; id_ex_reg_write = 1'b0; id_ex_rd = 5'd0;
        ex_mem_mem_read = 1'b0; ex_mem_reg_write = 1'b0; ex_mem_rd = 5'd0;
        mem_wait = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic lw_in_ex(input int rd);
        id_ex_mem_read = 1'b1; id_ex_reg_write = 1'b1; id_ex_rd = 5'(rd);
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_stall = 0;
        exp_flush = 0;
        reset = 1'b0;
        idle();
        #3;
        regs("rst", 0);
        ctl("rst", 1, 1, 1, 1, 0);
        id_pc_src = 2'b01;
        #1;
        chk("rst.flush_run_rule", 32'(if_flush), 32'd1);
        id_pc_src = 2'b00;
        @(negedge clk);
        reset = 1'b1;
        edge_step();
        regs("idle", 0);

        // lw $2 in EX, ID add $3,$2,$4: one load-use stall
        lw_in_ex(2); id_ins = rtype(2, 4, 3, 32'h20);
        #1; ctl("h1", 0, 0, 1, 0, 0);
        edge_step(); exp_stall = 1; regs("h1", 1);
        idle(); id_ins = rtype(2, 4, 3, 32'h20);
        #1; ctl("h1.after", 1, 1, 1, 1, 0);
        edge_step(); regs("h1.after", 0);

        // lw $5 in EX, ID beq $5,$6: H1 then H3
        lw_in_ex(5); id_ins = itype(4, 5, 6);
        #1; ctl("lwbr.c1", 0, 0, 1, 0, 0);
        edge_step(); exp_stall = 2; regs("lwbr.c1", 1);
        idle(); id_ins = itype(4, 5, 6);
        ex_mem_mem_read = 1'b1; ex_mem_reg_write = 1'b1; ex_mem_rd = 5'd5;
        #1; ctl("lwbr.c2", 0, 0, 1, 0, 0);
        chk("lwbr.c2.fwd_c", 32'(forward_c), 32'd0);
        edge_step(); exp_stall = 3; regs("lwbr.c2", 1);
        idle(); id_ins = itype(4, 5, 6);
        #1; ctl("lwbr.c3", 1, 1, 1, 1, 0);
        chk("lwbr.c3.fwd_c", 32'(forward_c), 32'd0);
        edge_step(); regs("lwbr.c3", 0);

        // add $7 in MEM, ID bne $1,$7: forward rt, no stall
        idle(); id_ins = itype(5, 1, 7);
        ex_mem_reg_write = 1'b1; ex_mem_rd = 5'd7;
        #1; ctl("fwd_d", 1, 1, 1, 1, 0);
        chk("fwd_d.d", 32'(forward_d), 32'd1);
        chk("fwd_d.c", 32'(forward_c), 32'd0);
        // jr $8 with $8 from MEM ALU result
        id_ins = rtype(8, 0, 0, 32'h08); ex_mem_rd = 5'd8;
        #1; chk("jr.fwd_c", 32'(forward_c), 32'd1);
        chk("jr.fwd_d", 32'(forward_d), 32'd0);
        // blez $8: no rt forwarding even if rt field matches
        id_ins = itype(6, 8, 8);
        #1; chk("blez.fwd_c", 32'(forward_c), 32'd1);
        chk("blez.fwd_d", 32'(forward_d), 32'd0);
        // non-branch never forwards in ID
        id_ins = rtype(8, 8, 3, 32'h20);
        #1; chk("add.fwd_c", 32'(forward_c), 32'd0);
        chk("add.fwd_d", 32'(forward_d), 32'd0);
        edge_step(); regs("fwd", 0);

        // taken beq, no hazard: one flush
        idle(); id_ins = itype(4, 1, 2); id_pc_src = 2'b01;
        #1; ctl("redir", 1, 1, 1, 1, 1);
        edge_step(); exp_flush = 1; regs("redir", 0);
        idle();
        #1; ctl("redir.after", 1, 1, 1, 1, 0);
        edge_step(); regs("redir.after", 0);

        // taken beq $5,$6 with ALU writing $6 in EX: redirect deferred
        idle(); id_ins = itype(4, 5, 6); id_pc_src = 2'b01;
        id_ex_reg_write = 1'b1; id_ex_rd = 5'd6;
        #1; ctl("h2redir", 0, 0, 1, 0, 0);
        edge_step(); exp_stall = 4; regs("h2redir", 1);
        id_ex_reg_write = 1'b0; id_ex_rd = 5'd0;
        #1; ctl("h2redir.run", 1, 1, 1, 1, 1);
        edge_step(); exp_flush = 2; regs("h2redir.run", 0);

        // freeze for 3 cycles over a load-use stall, then one stall
        idle(); lw_in_ex(2); id_ins = rtype(2, 4, 3, 32'h20); mem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1; ctl("frz", 0, 0, 0, 1, 0);
            edge_step(); regs("frz", 2);
        end
        mem_wait = 1'b0;
        #1; ctl("frz.rel", 0, 0, 1, 0, 0);
        edge_step(); exp_stall = 5; regs("frz.rel", 1);
        idle();
        #1; ctl("frz.done", 1, 1, 1, 1, 0);
        edge_step(); regs("frz.done", 0);

        // $0 destination and decode corner cases
        idle(); lw_in_ex(0); id_ins = rtype(0, 4, 3, 32'h20);
        #1; chk("r0.csel", 32'(control_sel), 32'd1);
        lw_in_ex(2); id_ins = itype(32'h0f, 2, 9);
        #1; chk("lui.csel", 32'(control_sel), 32'd1);
        id_ins = {6'h02, 26'h0440000};
        #1; chk("j.csel", 32'(control_sel), 32'd1);
        id_ins = itype(32'h0d, 4, 2);
        #1; chk("ori_rt.csel", 32'(control_sel), 32'd1);
        id_ins = itype(32'h2b, 4, 2);
        #1; chk("sw_rt.csel", 32'(control_sel), 32'd0);
        edge_step(); exp_stall = 6; regs("sw_rt", 1);

        // stall counter saturation at 15
        idle(); lw_in_ex(2); id_ins = rtype(2, 4, 3, 32'h20);
        for (int i = 0; i < 11; i++) begin
            edge_step();
            exp_stall = (exp_stall == 15) ? 15 : exp_stall + 1;
            regs("stall_sat", 1);
        end
        // flush counter saturation at 15
        idle(); id_ins = itype(4, 1, 2); id_pc_src = 2'b01;
        for (int i = 0; i < 15; i++) begin
            edge_step();
            exp_flush = (exp_flush == 15) ? 15 : exp_flush + 1;
            regs("flush_sat", 0);
        end
        // clear wins over increment
        clr_cnt = 1'b1;
        edge_step(); exp_stall = 0; exp_flush = 0; regs("clr", 0);
        idle(); lw_in_ex(2); id_ins = rtype(2, 4, 3, 32'h20);
        edge_step(); exp_stall = 1; regs("post_clr", 1);

        // async reset mid-stall
        #2; reset = 1'b0;
        #1; exp_stall = 0; regs("rst_mid", 0);
        ctl("rst_mid", 1, 1, 1, 1, 0);
        @(negedge clk);
        reset = 1'b1;
        idle();
        edge_step(); regs("rst_mid.after", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
